// File: rtl/dr_byte_fetcher_pkg.sv
// Shared types and constants for the data-register byte fetcher:
// sequencer states, fetch modes and the data register's function-select codes.
`timescale 1ns/1ps
package dr_byte_fetcher_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BE0 = 2'd0,
    BE1 = 2'd1,
    LE  = 2'd2
  } mode_t;

  localparam logic [1:0] DR_LD_SEXT = 2'b00;
  localparam logic [1:0] DR_LD_ZEXT = 2'b01;
  localparam logic [1:0] DR_SHL8    = 2'b10;
  localparam logic [1:0] DR_SHR8    = 2'b11;

  // Little-endian shifts every byte in from the top; big-endian loads the
  // first byte (extended) and shifts later bytes in from the bottom.
  function automatic logic [1:0] dr_funsel(input mode_t mode, input logic first);
    logic [1:0] sel;
    sel = DR_SHL8;
    if (mode == LE) begin
      sel = DR_SHR8;
    end else if (first) begin
      sel = (mode == BE1) ? DR_LD_SEXT : DR_LD_ZEXT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dr_byte_fetcher.sv
// Reads 1-4 consecutive bytes from byte-wide memory and steers the 32-bit data
// register (enable / function select / byte) so it ends up holding the operand.
`timescale 1ns/1ps
module dr_byte_fetcher
  import dr_byte_fetcher_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Count,
  input  logic              SignExt,
  input  logic              LittleEnd,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [7:0]        MemData,
  input  logic              MemValid,
  output logic              DrE,
  output logic [1:0]        DrFunSel,
  output logic [7:0]        DrI,
  output logic              Busy,
  output logic              Done,
  output state_t            State
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        remain_q, remain_d;
  mode_t             mode_q, mode_d;
  logic              first_q, first_d;
  logic [7:0]        byte_q, byte_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      mode_q   <= BE0;
      first_q  <= 1'b0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      first_q  <= first_d;
      byte_q   <= byte_d;
    end
  end

  // Memory handshake: MemRd is a one-cycle request issued only in REQ; the
  // response is the first MemValid seen while in WAIT (MemData valid with it).
  // Only one read is ever outstanding, and strobes outside WAIT are dropped.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    first_d  = first_q;
    byte_d   = byte_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          addr_d   = Addr;
          remain_d = Count;
          // Little-endian only makes sense for a full word.
          if (LittleEnd && (Count == 2'd3)) begin
            mode_d = LE;
          end else begin
            mode_d = SignExt ? BE1 : BE0;
          end
          first_d  = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (MemValid) begin
          byte_d  = MemData;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (remain_q == 2'd0) begin
          state_d = DONE;
        end else begin
          remain_d = remain_q - 2'd1;
          addr_d   = addr_q + ADDR_ONE;
          first_d  = 1'b0;
          state_d  = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state; no input reaches an output.
  assign MemAddr  = addr_q;
  assign MemRd    = (state_q == REQ);
  assign DrE      = (state_q == LOAD);
  assign DrFunSel = (state_q == LOAD) ? dr_funsel(mode_q, first_q) : DR_LD_SEXT;
  assign DrI      = byte_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign State    = state_q;

endmodule

// File: tb/tb_dr_byte_fetcher.sv
// Bench for dr_byte_fetcher: data register and latency-configurable memory
// downstream, table vectors, hand-written reset/robustness sequences, random fetches.
`timescale 1ns/1ps
module tb_dr_byte_fetcher;
  import dr_byte_fetcher_pkg::*;

  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] Addr = '0;
  logic [1:0]        Count = '0;
  logic              SignExt = 1'b0;
  logic              LittleEnd = 1'b0;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [7:0]        MemData = '0;
  logic              MemValid = 1'b0;
  logic              DrE;
  logic [1:0]        DrFunSel;
  logic [7:0]        DrI;
  logic              Busy;
  logic              Done;
  state_t            st;

  always #5 Clock = ~Clock;

  dr_byte_fetcher #(.ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr), .Count(Count),
    .SignExt(SignExt), .LittleEnd(LittleEnd), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemData(MemData), .MemValid(MemValid), .DrE(DrE), .DrFunSel(DrFunSel),
    .DrI(DrI), .Busy(Busy), .Done(Done), .State(st)
  );

  // ---------------- downstream data register (no reset) ----------------
  logic [31:0] dr_q = '0;
  always @(posedge Clock) begin
    if (DrE) begin
      case (DrFunSel)
        2'b00:   dr_q <= {{24{DrI[7]}}, DrI};
        2'b01:   dr_q <= {24'h0, DrI};
        2'b10:   dr_q <= {dr_q[23:0], DrI};
        default: dr_q <= {DrI, dr_q[31:8]};
      endcase
    end
  end

  // ---------------- memory model: response `lat` cycles after MemRd ----------------
  logic [7:0]        mem [0:65535];
  int                lat = 1;
  bit                spur = 1'b0;
  int                cd = 0;
  logic [ADDR_W-1:0] pa = '0;

  always @(negedge Clock or negedge Reset) begin
    if (!Reset) begin
      cd = 0;
      MemValid = 1'b0;
    end else begin
      MemValid = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          MemValid = 1'b1;
          MemData  = mem[pa];
        end
      end
      if (spur && MemRd) begin
        MemValid = 1'b1;
        MemData  = 8'hEE;
      end
      if (MemRd) begin
        cd = lat;
        pa = MemAddr;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int                n_vec = 0;
  int                n_mis = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  logic [1:0]        fs_q[$];
  int                ndre;
  int                consec;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: assemble the operand straight from memory contents.
  function automatic logic [31:0] model_reg(input logic [15:0] a, input int n,
                                            input bit s, input bit l);
    logic [31:0] v;
    v = 32'h0;
    if (l && n == 4) begin
      for (int i = 0; i < 4; i++) v = v | (32'(mem[a + 16'(i)]) << (8 * i));
    end else begin
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem[a + 16'(i)]);
      if (s && mem[a][7] && n < 4) v = v | (32'hFFFF_FFFF << (8 * n));
    end
    return v;
  endfunction

  function automatic int model_cyc(input int n, input int lt);
    return n * (lt + 2) + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic do_fetch(input logic [15:0] a, input logic [1:0] c, input logic s,
                          input logic l, input int lt, input bit noise,
                          output logic [31:0] got, output int cyc);
    bit prev;
    lat = lt;
    spur = noise;
    rd_q = {};
    fs_q = {};
    ndre = 0;
    consec = 0;
    prev = 1'b0;
    @(negedge Clock);
    Addr = a; Count = c; SignExt = s; LittleEnd = l; Start = 1'b1;
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
      if (MemRd) rd_q.push_back(MemAddr);
      if (DrE) begin
        fs_q.push_back(DrFunSel);
        ndre++;
        if (prev) consec++;
      end
      prev = DrE;
      if (noise) begin
        Start     = Done ? 1'b1 : 1'($urandom_range(0, 1));
        Addr      = 16'($urandom);
        Count     = 2'($urandom_range(0, 3));
        SignExt   = 1'($urandom_range(0, 1));
        LittleEnd = 1'($urandom_range(0, 1));
      end else begin
        Start = 1'b0;
      end
    end while (!Done && cyc < 400);
    got = dr_q;
    @(negedge Clock);
    Start = 1'b0;
    spur = 1'b0;
  endtask

  task automatic run_check(input logic [15:0] a, input logic [1:0] c, input logic s,
                           input logic l, input int lt, input bit noise,
                           input logic [31:0] exp_reg, input int exp_cyc);
    logic [31:0] got;
    int          cyc;
    int          n;
    bit          le_eff;
    logic [1:0]  efs;
    do_fetch(a, c, s, l, lt, noise, got, cyc);
    n = int'(c) + 1;
    le_eff = l && (c == 2'd3);
    chk("dr_value", got, exp_reg);
    chk("done_cycle", cyc, exp_cyc);
    chk("busy_after_done", 32'(Busy), 32'(0));
    chk("memrd_count", rd_q.size(), n);
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(a + 16'(i));
    while (exp_q.size() > 0 && rd_q.size() > 0)
      chk("memrd_addr", 32'(rd_q.pop_front()), 32'(exp_q.pop_front()));
    chk("dre_count", ndre, n);
    chk("dre_back_to_back", consec, 0);
    for (int i = 0; i < fs_q.size(); i++) begin
      if (le_eff)      efs = 2'b11;
      else if (i == 0) efs = s ? 2'b00 : 2'b01;
      else             efs = 2'b10;
      chk("funsel", 32'(fs_q[i]), 32'(efs));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_memaddr"}, 32'(MemAddr), 32'(0));
    chk({tag, "_memrd"}, 32'(MemRd), 32'(0));
    chk({tag, "_dre"}, 32'(DrE), 32'(0));
    chk({tag, "_funsel"}, 32'(DrFunSel), 32'(0));
    chk({tag, "_dri"}, 32'(DrI), 32'(0));
    chk({tag, "_busy"}, 32'(Busy), 32'(0));
    chk({tag, "_done"}, 32'(Done), 32'(0));
    chk({tag, "_state"}, 32'(st), 32'(IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  cnt;
    logic        sext;
    logic        le;
    int          lt;
    bit          noise;
    logic [31:0] bytes;   // b0 in [31:24] .. b3 in [7:0]
    logic [31:0] exp_reg;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] bw;
    logic [15:0] ra;
    logic [1:0]  rc;
    logic        rs, rl;
    int          rlt, nrd, k;
    bit          rn;

    vecs[0] = '{16'h0010, 2'd3, 1'b0, 1'b0, 1, 1'b0, 32'h12345678, 32'h12345678, 13};
    vecs[1] = '{16'h0010, 2'd3, 1'b0, 1'b1, 1, 1'b0, 32'h12345678, 32'h78563412, 13};
    vecs[2] = '{16'h0020, 2'd1, 1'b1, 1'b0, 1, 1'b0, 32'hF00F0000, 32'hFFFFF00F, 7};
    vecs[3] = '{16'h0020, 2'd1, 1'b0, 1'b0, 1, 1'b0, 32'hF00F0000, 32'h0000F00F, 7};
    vecs[4] = '{16'h0030, 2'd0, 1'b1, 1'b1, 1, 1'b0, 32'h80000000, 32'hFFFFFF80, 4};
    vecs[5] = '{16'hFFFF, 2'd1, 1'b0, 1'b0, 3, 1'b0, 32'hABCD0000, 32'h0000ABCD, 11};
    vecs[6] = '{16'h0040, 2'd2, 1'b1, 1'b1, 2, 1'b0, 32'h7F010200, 32'h007F0102, 13};
    vecs[7] = '{16'h0010, 2'd3, 1'b0, 1'b0, 2, 1'b1, 32'h12345678, 32'h12345678, 17};
    vecs[8] = '{16'h0050, 2'd0, 1'b0, 1'b0, 1, 1'b1, 32'h9C000000, 32'h0000009C, 4};

    // Reset held at time zero.
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge Clock);
    chk_reset_outputs("reset_held");
    Reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      bw = vecs[v].bytes;
      for (int i = 0; i < 4; i++) mem[vecs[v].addr + 16'(i)] = bw[31 - 8 * i -: 8];
      run_check(vecs[v].addr, vecs[v].cnt, vecs[v].sext, vecs[v].le, vecs[v].lt,
                vecs[v].noise, vecs[v].exp_reg, vecs[v].exp_cyc);
    end

    // Reset during the second WAIT of a 4-byte fetch.
    mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hB2;
    mem[16'h0102] = 8'hC3; mem[16'h0103] = 8'hD4;
    lat = 2;
    @(negedge Clock);
    Addr = 16'h0100; Count = 2'd3; SignExt = 1'b0; LittleEnd = 1'b0; Start = 1'b1;
    nrd = 0;
    k = 0;
    do begin
      @(negedge Clock);
      Start = 1'b0;
      k++;
      if (MemRd) nrd++;
    end while (nrd < 2 && k < 50);
    @(negedge Clock);
    chk("second_wait_reached", 32'(st), 32'(WAIT));
    Reset = 1'b0;
    #1;
    chk_reset_outputs("midfetch_reset");
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    run_check(16'h0100, 2'd3, 1'b0, 1'b0, 1, 1'b0,
              model_reg(16'h0100, 4, 1'b0, 1'b0), model_cyc(4, 1));

    // Random fetches against the reference model.
    for (int t = 0; t < 40; t++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
      rc  = 2'($urandom_range(0, 3));
      rs  = 1'($urandom_range(0, 1));
      rl  = 1'($urandom_range(0, 1));
      rlt = $urandom_range(1, 4);
      rn  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) mem[ra + 16'(i)] = 8'($urandom);
      run_check(ra, rc, rs, rl, rlt, rn,
                model_reg(ra, int'(rc) + 1, rs, rl), model_cyc(int'(rc) + 1, rlt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dr_byte_fetcher.md
# dr_byte_fetcher

Sequencer that sits directly upstream of the 32-bit data register: it reads 1–4 consecutive bytes from the byte-wide data memory and drives the register's enable, function-select and byte input so the register ends up holding the assembled operand. The block supports big-endian assembly with zero or sign extension, and little-endian full-word assembly. It replaces hand-sequenced control-unit micro-steps for multi-byte loads, and reports completion with a one-cycle pulse.

## Interface
- ADDR_W, 16, memory address width

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request a fetch; sampled only in IDLE
- Addr  in  ADDR_W  address of first byte
- Count  in  2  number of bytes minus one (0 → 1 byte … 3 → 4 bytes)
- SignExt  in  1  big-endian only: 1 = sign-extend first byte, 0 = zero-extend
- LittleEnd  in  1  1 = little-endian; honoured only when Count=3, otherwise treated as 0
- MemAddr  out  ADDR_W  byte address of current request
- MemRd  out  1  one-cycle read request
- MemData  in  8  read data, valid with MemValid
- MemValid  in  1  read response strobe, one or more cycles after MemRd
- DrE  out  1  data register enable
- DrFunSel  out  2  data register function select
- DrI  out  8  byte to data register
- Busy  out  1  high from the cycle after accepted Start until the end of DONE
- Done  out  1  one-cycle pulse; the data register already holds the final value

## Operation
- States: IDLE, REQ, WAIT, LOAD, DONE.
- IDLE with Start=1:
  - Latch Addr into the address counter.
  - Latch Count into the remaining counter.
  - Latch the mode: BE0 (zero-extend), BE1 (sign-extend) or LE.
  - Clear the first-byte flag to "first".
  - Go to REQ.
- REQ: MemRd=1, MemAddr=counter. Go to WAIT.
- WAIT: hold until MemValid=1. Capture MemData into the byte register, then go to LOAD.
- LOAD: DrE=1, DrI=byte register. DrFunSel is selected as follows:
  - LE mode: 2'b11 for every byte.
  - Big-endian, first byte: 2'b00 if SignExt, else 2'b01.
  - Big-endian, later bytes: 2'b10.
- End of LOAD:
  - If remaining=0, go to DONE.
  - Otherwise decrement remaining, increment the address (mod 2^ADDR_W), clear "first", and go to REQ.
- DONE: Done=1. Next state is IDLE.
- Resulting register contents (b0 is the byte at Addr):
  - BE, 4 bytes: {b0,b1,b2,b3}
  - BE, 2 bytes, sign-extended: {16{b0[7]},b0,b1}
  - LE, 4 bytes: {b3,b2,b1,b0}
  - 1 byte: the byte zero- or sign-extended.
- Boundary conditions:
  - Start outside IDLE is ignored; the current fetch is unaffected.
  - MemValid outside WAIT is ignored, and its data is discarded.
  - Address wrap: 0xFFFF+1 → 0x0000 with no error.
  - Start in the DONE cycle is ignored. Start is accepted in the following IDLE cycle.
- Reset (asserted at any time, including mid-fetch): state=IDLE, all counters cleared. The data register keeps whatever partial value it holds, so the control unit must not consume it.

## Timing
- Reset values: MemAddr=0, MemRd=0, DrE=0, DrFunSel=2'b00, DrI=0, Busy=0, Done=0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- With zero-wait memory (MemValid one cycle after MemRd), each byte costs 3 cycles (REQ, WAIT, LOAD).
- An N-byte fetch with zero-wait memory takes 3N+1 cycles from the Start-sampling edge to the Done cycle inclusive.
- Each extra memory wait cycle adds one cycle in WAIT.
- MemRd is high for exactly one cycle per byte.
- At most one memory request is outstanding at a time.
- DrE is high for exactly N cycles per fetch, never consecutive.

## Structure
- The shared package holds:
  - the state enum (IDLE, REQ, WAIT, LOAD, DONE);
  - the data-register FunSel constants: DR_LD_SEXT=2'b00, DR_LD_ZEXT=2'b01, DR_SHL8=2'b10, DR_SHR8=2'b11;
  - the mode enum (BE0, BE1, LE).
- The block is a single module with no sub-modules.
- The bench instantiates the existing data register downstream of this block, plus a memory model with configurable latency.

## Test plan
- BE 4-byte, zero-wait: mem[0x0010..13]=12 34 56 78, Addr=0x0010, Count=3, SignExt=0 → register=0x12345678; Done on cycle 13 after Start; exactly 4 MemRd pulses at 0x10..0x13.
- LE 4-byte: same memory, LittleEnd=1 → register=0x78563412.
- BE 2-byte sign-extended: mem[0x20..21]=F0 0F, Count=1, SignExt=1 → register=0xFFFFF00F. With SignExt=0 → 0x0000F00F.
- Ignored LE flag and 1-byte fetch: LittleEnd=1, Count=0, SignExt=1, mem[0x30]=80 → register=0xFFFFFF80, using FunSel 00 only.
- Wait states and wrap: memory latency 3 cycles, Addr=0xFFFF, Count=1, mem[0xFFFF]=AB, mem[0x0000]=CD → MemAddr sequence FFFF then 0000; register=0x0000ABCD; Done on cycle 11.
- Robustness:
  - Start pulses while Busy and a spurious MemValid in REQ leave the result unchanged.
  - Reset asserted during the second WAIT → all outputs return to reset values immediately.
  - A new fetch after reset completes correctly.
